pulse_tracker: RTL and testbench
================================

PULSE_TRACKER -- requirements
Module: pulse_tracker

Interface
REQ-001 The block SHALL have parameter MAX_PERIOD, default 1024, giving the longest pulse interval in cycles that can be tracked (minimum 1).
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4, giving the number of consecutive equal intervals required to lock (minimum 1).
REQ-003 The block SHALL have parameter LOSS_COUNT, default 2, giving the number of consecutive bad or missing pulses that drop lock (minimum 1).
REQ-004 The block SHALL have derived localparam CW = $clog2(MAX_PERIOD+2).
REQ-005 The block SHALL have port clk, input, 1 bit: clock, with all logic on posedge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port pulse_in, input, 1 bit: a single-cycle or level pulse stream synchronous to clk, where every high cycle counts as one pulse.
REQ-008 The block SHALL have port clear_errors, input, 1 bit: clears error_count.
REQ-009 The block SHALL have port locked, output, 1 bit: a stable period has been acquired.
REQ-010 The block SHALL have port period, output, CW bits: the locked interval in cycles, valid while locked=1.
REQ-011 The block SHALL have port expected, output, 1 bit: a pulse is predicted this cycle (flywheel).
REQ-012 The block SHALL have port missed, output, 1 bit: one-cycle strobe for each missing or early pulse while locked.
REQ-013 The block SHALL have port error_count, output, 8 bits: count of missed strobes, saturating.

Function
REQ-014 Interval counter cnt SHALL be 1 in the cycle after a pulse and increment each cycle, saturating at MAX_PERIOD+1; the interval of a pulse is the value of cnt in that pulse's cycle.
REQ-015 A pulse_in that is high every cycle SHALL measure interval 1.
REQ-016 Pulses spaced N cycles apart SHALL measure interval N.
REQ-017 States: IDLE, MEASURE, LOCKING, LOCKED.
REQ-018 IDLE: on pulse_in, the block SHALL move to MEASURE with cnt restarting.
REQ-019 MEASURE: on pulse_in, the block SHALL latch candidate=cnt, set match=1, and move to LOCKING.
REQ-020 MEASURE and LOCKING: if cnt reaches MAX_PERIOD+1, the block SHALL return to IDLE.
REQ-021 LOCKING: on a pulse with cnt==candidate, match SHALL increment.
REQ-022 LOCKING: on a pulse with cnt!=candidate, the block SHALL set candidate=cnt and match=1.
REQ-023 LOCKING: when match reaches LOCK_COUNT, the block SHALL move to LOCKED with period=candidate.
REQ-024 LOCK_COUNT=1 SHALL lock on the first measured interval.
REQ-025 locked SHALL be a registered output, asserted in the cycle after the pulse that completes LOCK_COUNT matches.
REQ-026 LOCKED: expected SHALL be 1 in exactly those cycles where cnt==period, and SHALL be 0 in every other state.
REQ-027 LOCKED, pulse with cnt==period: the pulse is good; the block SHALL clear miss_run and restart cnt.
REQ-028 LOCKED, no pulse with cnt==period: the block SHALL assert missed in the next cycle, increment miss_run, and restart cnt as if a pulse occurred.
REQ-029 LOCKED, pulse with cnt<period (early): the block SHALL assert missed in the next cycle, increment miss_run, and restart cnt (realign).
REQ-030 When miss_run reaches LOSS_COUNT, the block SHALL deassert locked in the same cycle as that missed strobe and go to IDLE.
REQ-031 If the final miss was an early pulse, the block SHALL go to MEASURE instead of IDLE.
REQ-032 error_count SHALL increment on each missed strobe and hold at 255.
REQ-033 clear_errors SHALL set error_count to 0 next cycle, winning over a simultaneous increment.
REQ-034 period SHALL hold its last locked value when lock is lost; it is don't-care while locked=0.

Reset
REQ-035 When reset=1, the block SHALL set state=IDLE, cnt=0, candidate=0, match=0, miss_run=0, period=0, error_count=0, locked=0, expected=0, and missed=0 on the next edge.
REQ-036 Reset asserted mid-operation SHALL abort lock immediately, and pulse_in SHALL be ignored during reset.

Structure
REQ-037 The state enum and the error counter width SHALL live in shared package pulse_tracker_pkg.
REQ-038 The block SHALL be a single module with no sub-module; widths SHALL come from parameters only.

Verification
REQ-039 Pulses at cycles 0,4,8,12,16, LOCK_COUNT=4 -> locked=1 from cycle 17, period=4, expected high at cycle 20.
REQ-040 pulse_in held high, LOCK_COUNT=4 -> locked from cycle 5, period=1, missed never asserted.
REQ-041 Locked at period=4, pulse at cycle 24 omitted -> missed=1 at cycle 25, error_count=1; pulse at 28 restores miss_run=0 and lock holds.
REQ-042 Locked at period=4, LOSS_COUNT=2, pulses stop -> missed at +1 and +5 cycles after the missing slots, locked=0 with the second strobe, state IDLE.
REQ-043 Locked at period=8, early pulse at cnt=3 -> missed strobe next cycle, expected realigned 8 cycles after the early pulse; 256 misses leave error_count=255; clear_errors together with a miss gives 0.
REQ-044 Reset asserted during LOCKING and during LOCKED -> all outputs 0 the next cycle, and relock requires a full LOCK_COUNT sequence.

Source files
------------

// File: rtl/pulse_tracker_pkg.sv
// Shared definitions for the pulse tracker: FSM encoding and error counter sizing.
package pulse_tracker_pkg;

  // Tracker FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKING = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Error counter width and its saturation value.
  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/pulse_tracker.sv
// Pulse period tracker: measures the spacing of pulses on pulse_in, locks after
// LOCK_COUNT consecutive equal intervals, then flywheels a prediction of the
// next pulse and flags missing or early pulses until LOSS_COUNT consecutive
// bad slots drop the lock. fsm_state exposes the FSM for observation.
module pulse_tracker
  import pulse_tracker_pkg::*;
#(
  parameter int MAX_PERIOD = 1024,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  localparam int CW = $clog2(MAX_PERIOD + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             clear_errors,
  output logic             locked,
  output logic [CW-1:0]    period,
  output logic             expected,
  output logic             missed,
  output logic [ERR_W-1:0] error_count,
  output state_t           fsm_state
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CW-1:0]    candidate, candidate_n;
  logic [MW-1:0]    match, match_n;
  logic [LW-1:0]    miss_run, miss_run_n;
  logic [CW-1:0]    period_q, period_n;
  logic             locked_q, locked_n;
  logic             missed_q, missed_n;
  logic [ERR_W-1:0] err_q;

  // Slot classification while locked: a pulse in the predicted slot is good,
  // a pulse before it is early, and an empty predicted slot is a miss.
  logic slot_hit;
  logic pulse_good;
  logic pulse_early;
  logic slot_empty;

  assign slot_hit    = (cnt == period_q);
  assign pulse_good  = pulse_in && slot_hit;
  assign pulse_early = pulse_in && (cnt < period_q);
  assign slot_empty  = !pulse_in && slot_hit;

  // Next-state, interval counter and lock bookkeeping.
  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    candidate_n = candidate;
    match_n     = match;
    miss_run_n  = miss_run;
    period_n    = period_q;
    locked_n    = locked_q;
    missed_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pulse_in) begin
          state_n = ST_MEASURE;
          cnt_n   = CNT_ONE;
        end
      end

      ST_MEASURE: begin
        if (cnt == CNT_MAX) begin
          // Interval too long to track; give up and wait for a fresh pulse.
          state_n = ST_IDLE;
        end else if (pulse_in) begin
          cnt_n       = CNT_ONE;
          candidate_n = cnt;
          match_n     = MW'(1);
          if (LOCK_COUNT == 1) begin
            state_n    = ST_LOCKED;
            period_n   = cnt;
            locked_n   = 1'b1;
            miss_run_n = '0;
          end else begin
            state_n = ST_LOCKING;
          end
        end
      end

      ST_LOCKING: begin
        if (cnt == CNT_MAX) begin
          state_n = ST_IDLE;
        end else if (pulse_in) begin
          cnt_n = CNT_ONE;
          if (cnt == candidate) begin
            match_n = match + 1'b1;
            if (int'(match) + 1 == LOCK_COUNT) begin
              state_n    = ST_LOCKED;
              period_n   = candidate;
              locked_n   = 1'b1;
              miss_run_n = '0;
            end
          end else begin
            // New interval seen: restart the match run around it.
            candidate_n = cnt;
            match_n     = MW'(1);
          end
        end
      end

      ST_LOCKED: begin
        if (pulse_good) begin
          cnt_n      = CNT_ONE;
          miss_run_n = '0;
        end else if (pulse_early || slot_empty) begin
          // Realign to the early pulse, or flywheel over the empty slot.
          cnt_n    = CNT_ONE;
          missed_n = 1'b1;
          if (int'(miss_run) + 1 == LOSS_COUNT) begin
            locked_n   = 1'b0;
            miss_run_n = '0;
            // An early pulse is itself a usable start for a new measurement.
            state_n    = pulse_early ? ST_MEASURE : ST_IDLE;
          end else begin
            miss_run_n = miss_run + 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      candidate <= '0;
      match     <= '0;
      miss_run  <= '0;
      period_q  <= '0;
      locked_q  <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      candidate <= candidate_n;
      match     <= match_n;
      miss_run  <= miss_run_n;
      period_q  <= period_n;
      locked_q  <= locked_n;
      missed_q  <= missed_n;
    end
  end

  // Saturating error counter; clear wins over a coincident miss.
  always_ff @(posedge clk) begin
    if (reset || clear_errors) begin
      err_q <= '0;
    end else if (missed_n && (err_q != ERR_MAX)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign locked      = locked_q;
  assign period      = period_q;
  assign expected    = (state == ST_LOCKED) && slot_hit;
  assign missed      = missed_q;
  assign error_count = err_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_pulse_tracker.sv
// Self-checking bench for pulse_tracker. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, so "cycle N" values are those seen
// before the rising edge that samples cycle N's inputs.
module tb_pulse_tracker;
  import pulse_tracker_pkg::*;

  localparam int CWA = $clog2(1024 + 2);
  localparam int CWB = $clog2(8 + 2);

  logic clk = 1'b0;
  logic reset;
  logic pulse_in;
  logic clear_errors;

  logic           locked_a, expected_a, missed_a;
  logic [CWA-1:0] period_a;
  logic [7:0]     err_a;
  state_t         st_a;

  logic           locked_b, expected_b, missed_b;
  logic [CWB-1:0] period_b;
  logic [7:0]     err_b;
  state_t         st_b;

  int errors = 0;
  int checks = 0;

  // Default configuration.
  pulse_tracker dut_a (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .clear_errors (clear_errors),
    .locked       (locked_a),
    .period       (period_a),
    .expected     (expected_a),
    .missed       (missed_a),
    .error_count  (err_a),
    .fsm_state    (st_a)
  );

  // Single-interval lock, single-miss loss, short tracking range.
  pulse_tracker #(.MAX_PERIOD(8), .LOCK_COUNT(1), .LOSS_COUNT(1)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .pulse_in     (pulse_in),
    .clear_errors (clear_errors),
    .locked       (locked_b),
    .period       (period_b),
    .expected     (expected_b),
    .missed       (missed_b),
    .error_count  (err_b),
    .fsm_state    (st_b)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int lck;
    int per;   // -1: not checked
    int exp;
    int mis;
    int err;
    int st;    // -1: not checked
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // One clock cycle of stimulus.
  task automatic cyc(input logic p, input logic c, input logic r);
    @(negedge clk);
    pulse_in     = p;
    clear_errors = c;
    reset        = r;
    #1;
  endtask

  // Two reset cycles with pulse_in held high (must be ignored).
  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
  endtask

  task automatic check_vec_a(input vec_t v);
    string t;
    t = $sformatf("s1_c%0d", v.cyc);
    chk({t, "_locked"}, int'(locked_a), v.lck);
    if (v.per >= 0) chk({t, "_period"}, int'(period_a), v.per);
    chk({t, "_expected"}, int'(expected_a), v.exp);
    chk({t, "_missed"}, int'(missed_a), v.mis);
    chk({t, "_errcnt"}, int'(err_a), v.err);
    if (v.st >= 0) chk({t, "_state"}, int'(st_a), v.st);
  endtask

  function automatic logic s1_pulse(input int c);
    return (c % 4 == 0) && (c <= 36) && (c != 24) && (c != 32);
  endfunction

  initial begin
    int k;
    reset        = 1'b1;
    pulse_in     = 1'b0;
    clear_errors = 1'b0;

    // Seq 1: period-4 lock, isolated miss with recovery, then loss of lock.
    tbl = '{
      '{0,  0, -1, 0, 0, 0, int'(ST_IDLE)},
      '{1,  0, -1, 0, 0, 0, int'(ST_MEASURE)},
      '{5,  0, -1, 0, 0, 0, int'(ST_LOCKING)},
      '{16, 0, -1, 0, 0, 0, int'(ST_LOCKING)},
      '{17, 1,  4, 0, 0, 0, int'(ST_LOCKED)},
      '{20, 1,  4, 1, 0, 0, int'(ST_LOCKED)},
      '{21, 1,  4, 0, 0, 0, -1},
      '{24, 1,  4, 1, 0, 0, -1},
      '{25, 1,  4, 0, 1, 1, int'(ST_LOCKED)},
      '{26, 1,  4, 0, 0, 1, -1},
      '{28, 1,  4, 1, 0, 1, -1},
      '{29, 1,  4, 0, 0, 1, -1},
      '{33, 1,  4, 0, 1, 2, -1},
      '{37, 1,  4, 0, 0, 2, -1},
      '{41, 1,  4, 0, 1, 3, int'(ST_LOCKED)},
      '{44, 1,  4, 1, 0, 3, -1},
      '{45, 0, -1, 0, 1, 4, int'(ST_IDLE)},
      '{46, 0, -1, 0, 0, 4, int'(ST_IDLE)}
    };
    do_reset();
    k = 0;
    for (int c = 0; c <= 46; c++) begin
      cyc(s1_pulse(c), 1'b0, 1'b0);
      if (k < 18 && tbl[k].cyc == c) begin
        check_vec_a(tbl[k]);
        k++;
      end
    end

    // Seq 2: pulse_in held high measures interval 1.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("s2_c%0d_missed", c), int'(missed_a), 0);
      if (c == 4) chk("s2_c4_locked", int'(locked_a), 0);
      if (c == 5) begin
        chk("s2_c5_locked", int'(locked_a), 1);
        chk("s2_c5_period", int'(period_a), 1);
      end
      if (c >= 5) chk($sformatf("s2_c%0d_expected", c), int'(expected_a), 1);
    end

    // Seq 3: period 8, early pulse realign, error saturation, clear vs miss.
    do_reset();
    for (int c = 0; c <= 43; c++) begin
      cyc((c % 8 == 0 && c <= 32) || c == 35 || c == 43, 1'b0, 1'b0);
      if (c == 32) chk("s3_c32_locked", int'(locked_a), 0);
      if (c == 33) begin
        chk("s3_c33_locked", int'(locked_a), 1);
        chk("s3_c33_period", int'(period_a), 8);
      end
      if (c == 35) chk("s3_c35_missed", int'(missed_a), 0);
      if (c == 36) begin
        chk("s3_c36_missed", int'(missed_a), 1);
        chk("s3_c36_errcnt", int'(err_a), 1);
        chk("s3_c36_locked", int'(locked_a), 1);
      end
      if (c == 42) chk("s3_c42_expected", int'(expected_a), 0);
      if (c == 43) chk("s3_c43_expected", int'(expected_a), 1);
    end
    for (int it = 0; it < 255; it++) begin
      for (int j = 1; j <= 16; j++) begin
        cyc(j == 16, 1'b0, 1'b0);
        if (j == 8)  chk($sformatf("s3_it%0d_expected", it), int'(expected_a), 1);
        if (j == 9)  chk($sformatf("s3_it%0d_missed", it), int'(missed_a), 1);
      end
    end
    chk("s3_err_sat", int'(err_a), 255);
    chk("s3_sat_locked", int'(locked_a), 1);
    for (int j = 1; j <= 16; j++) cyc(j == 16, 1'b0, 1'b0);
    chk("s3_err_hold", int'(err_a), 255);
    for (int j = 1; j <= 8; j++) cyc(1'b0, j == 8, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("s3_clr_missed", int'(missed_a), 1);
    chk("s3_clr_errcnt", int'(err_a), 0);
    chk("s3_clr_locked", int'(locked_a), 1);

    // Seq 4: reset during LOCKING and during LOCKED.
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      logic r;
      r = (c == 10) || (c == 33);
      cyc(r || c == 0 || c == 4 || c == 8 || c == 11 || c == 15 ||
          c == 19 || c == 23 || c == 27, 1'b0, r);
      if (c == 9) chk("s4_c9_state", int'(st_a), int'(ST_LOCKING));
      if (c == 11 || c == 34) begin
        chk($sformatf("s4_c%0d_locked", c), int'(locked_a), 0);
        chk($sformatf("s4_c%0d_missed", c), int'(missed_a), 0);
        chk($sformatf("s4_c%0d_errcnt", c), int'(err_a), 0);
        chk($sformatf("s4_c%0d_expected", c), int'(expected_a), 0);
        chk($sformatf("s4_c%0d_state", c), int'(st_a), int'(ST_IDLE));
      end
      if (c == 24) chk("s4_c24_locked", int'(locked_a), 0);
      if (c == 28) begin
        chk("s4_c28_locked", int'(locked_a), 1);
        chk("s4_c28_period", int'(period_a), 4);
      end
      if (c == 32) begin
        chk("s4_c32_missed", int'(missed_a), 1);
        chk("s4_c32_errcnt", int'(err_a), 1);
      end
    end

    // Seq 5 (dut_b): LOCK_COUNT=1, LOSS_COUNT=1, early loss to MEASURE,
    // slot loss to IDLE, and overflow of the interval counter.
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      cyc(c == 0 || c == 3 || c == 5 || c == 9 || c == 16, 1'b0, 1'b0);
      case (c)
        0: begin
          chk("s5_c0_locked", int'(locked_b), 0);
          chk("s5_c0_state", int'(st_b), int'(ST_IDLE));
        end
        3: begin
          chk("s5_c3_locked", int'(locked_b), 0);
          chk("s5_c3_state", int'(st_b), int'(ST_MEASURE));
        end
        4: begin
          chk("s5_c4_locked", int'(locked_b), 1);
          chk("s5_c4_period", int'(period_b), 3);
          chk("s5_c4_state", int'(st_b), int'(ST_LOCKED));
        end
        5: chk("s5_c5_expected", int'(expected_b), 0);
        6: begin
          chk("s5_c6_missed", int'(missed_b), 1);
          chk("s5_c6_locked", int'(locked_b), 0);
          chk("s5_c6_state", int'(st_b), int'(ST_MEASURE));
          chk("s5_c6_errcnt", int'(err_b), 1);
        end
        10: begin
          chk("s5_c10_locked", int'(locked_b), 1);
          chk("s5_c10_period", int'(period_b), 4);
        end
        13: chk("s5_c13_expected", int'(expected_b), 1);
        14: begin
          chk("s5_c14_missed", int'(missed_b), 1);
          chk("s5_c14_locked", int'(locked_b), 0);
          chk("s5_c14_state", int'(st_b), int'(ST_IDLE));
          chk("s5_c14_errcnt", int'(err_b), 2);
        end
        17: chk("s5_c17_state", int'(st_b), int'(ST_MEASURE));
        25: chk("s5_c25_state", int'(st_b), int'(ST_MEASURE));
        26: chk("s5_c26_state", int'(st_b), int'(ST_IDLE));
        default: ;
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
